dma_burst_sequencer: RTL and testbench
======================================

# dma_burst_sequencer

Control FSM for one DMA channel. It moves a block of words from a source address to a destination address in bursts, staging each burst in the channel's staging FIFO. The FIFO must be built fall-through. For each burst the block reads up to BURST_MAX beats from the source into the FIFO, then writes them out to the destination. It drives the FIFO's wr_en/rd_en/response pins and a beat-level request/ready interface to the AHB master engine. The data path (bus rdata → FIFO data_in → bus wdata) is wired in the parent, not here.

## Interface
- ADDR_W, 32, bus address width
- DATA_W, 32, beat width; address stride = DATA_W/8 bytes
- LEN_W, 16, transfer length counter width (in beats)
- BURST_MAX, 8, maximum beats per burst; must equal the FIFO depth and be a power of 2
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE
- src_addr  in  ADDR_W  source base address, captured on start
- dst_addr  in  ADDR_W  destination base address, captured on start
- xfer_len  in  LEN_W  number of beats, captured on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky bus-error flag; cleared by the next accepted start
- bus_req  out  1  beat request to the master engine
- bus_write  out  1  0 = read from source, 1 = write to destination
- bus_addr  out  ADDR_W  beat address
- bus_ready  in  1  current beat completed (read data valid, or write accepted)
- bus_err  in  1  error response on the current beat; qualified by bus_ready
- fifo_wr_en  out  1  connects to FIFO wr_en
- fifo_rd_en  out  1  connects to FIFO rd_en
- fifo_clr  out  1  connects to FIFO response (clears both FIFO pointers)

## Operation
- States: IDLE, RD_BURST, WR_BURST, NEXT, DONE, ERR.
- IDLE:
  - If start=1 and xfer_len≠0: capture src_ptr, dst_ptr and remaining; compute burst = min(remaining, BURST_MAX); clear beat_cnt; go to RD_BURST. Clear err.
  - If start=1 and xfer_len=0: clear err and go to DONE; no bus activity.
- RD_BURST: bus_req=1, bus_write=0, bus_addr=src_ptr.
  - fifo_wr_en = bus_ready & ~bus_err (combinational).
  - On each good beat: src_ptr += DATA_W/8 and beat_cnt++.
  - On the last beat (beat_cnt=burst−1): clear beat_cnt and go to WR_BURST.
- WR_BURST: bus_req=1, bus_write=1, bus_addr=dst_ptr.
  - fifo_rd_en = bus_ready & ~bus_err; FIFO data_out is already valid because the FIFO is fall-through.
  - On each good beat: dst_ptr += DATA_W/8.
  - On the last beat: remaining −= burst. If the result is 0, go to DONE; otherwise go to NEXT.
- NEXT: fifo_clr=1 for one cycle; burst = min(remaining, BURST_MAX); go to RD_BURST.
- DONE: done=1 and fifo_clr=1 for one cycle; go to IDLE.
- ERR: entered on bus_ready & bus_err in either burst state. err is set; fifo_clr=1 for one cycle; go to IDLE. done is not pulsed.
- start is ignored while busy=1.
- Address pointers wrap modulo 2^ADDR_W. Length arithmetic is unsigned LEN_W bits.

## Timing
- Reset values: state=IDLE; busy=0, done=0, err=0, bus_req=0, bus_write=0, bus_addr=0, fifo_wr_en=0, fifo_rd_en=0, fifo_clr=0. Internal pointers and counters reset to 0.
- bus_req, bus_write and bus_addr are registered, derived from state and pointers.
- fifo_wr_en and fifo_rd_en are combinational from bus_ready, bus_err and state.
- If start is accepted in cycle N, bus_req rises in cycle N+1.
- With bus_ready tied high, done is high in cycle N+1+2L+(ceil(L/BURST_MAX)−1).
- bus_ready=0 stalls the current beat indefinitely; address and counters hold.
- Reset asserted mid-transfer aborts immediately to the reset values; the FIFO is reset by the same rst_n.

## Configuration
- DMA_SEQ_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 in any busy state other than DONE/ERR goes to ERR on the next edge, even mid-beat. err is not set; a sticky aborted output (1 bit) is set instead and cleared on the next start.
- DMA_SEQ_ABORT_EN undefined: the abort and aborted ports do not exist, and a transfer ends only by DONE, ERR or reset.

## Structure
- Package dma_seq_pkg holds:
  - the state enum dma_seq_state_e;
  - the function min_burst(remaining, BURST_MAX);
  - the localparam for bytes per beat.
- There is no sub-module. The staging FIFO and the AHB master engine are instantiated by the channel top, alongside this block.

## Test plan
- L=3, src=0x100, dst=0x200, bus_ready=1, start at cycle 0 → reads at 0x100/0x104/0x108 in cycles 1–3, writes at 0x200/0x204/0x208 in cycles 4–6, done in cycle 7, destination data equals source data.
- L=10, BURST_MAX=8 → bursts of 8 then 2, fifo_clr pulses once in NEXT, done in cycle 22, all 10 words copied in order.
- L=0 → done in cycle 1, bus_req never asserted.
- bus_err on the 2nd read beat of L=4 → no fifo_wr_en on that beat, ERR then IDLE, err=1, no done, next start clears err.
- Random bus_ready stalls (50%) with L=17 → output data and addresses identical to the no-stall run; start pulses sent while busy are ignored.
- rst_n asserted in mid-WR_BURST → all outputs return to reset values asynchronously; a new L=2 transfer then completes correctly.

Source files
------------

// File: rtl/dma_seq_pkg.sv
// Shared types and helpers for the DMA burst sequencer: state encoding,
// beat stride and burst-length clamp.
package dma_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_BURST = 3'd1,
        S_WR_BURST = 3'd2,
        S_NEXT     = 3'd3,
        S_DONE     = 3'd4,
        S_ERR      = 3'd5
    } dma_seq_state_e;

    localparam int unsigned DMA_SEQ_DATA_W         = 32;
    localparam int unsigned DMA_SEQ_BYTES_PER_BEAT = DMA_SEQ_DATA_W / 8;

    function automatic int unsigned min_burst(input int unsigned remaining,
                                              input int unsigned burst_max);
        return (remaining < burst_max) ? remaining : burst_max;
    endfunction

endpackage

// File: rtl/dma_burst_sequencer.sv
// Per-channel DMA control FSM: reads bursts from source into a fall-through
// staging FIFO, then writes them to destination. Optional abort: DMA_SEQ_ABORT_EN.
module dma_burst_sequencer
    import dma_seq_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  xfer_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              bus_req,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_ready,
    input  logic              bus_err,
    output logic              fifo_wr_en,
    output logic              fifo_rd_en,
`ifdef DMA_SEQ_ABORT_EN
    input  logic              abort,
    output logic              aborted,
`endif
    output logic              fifo_clr
);

    localparam int unsigned STRIDE_BYTES = (DATA_W == DMA_SEQ_DATA_W) ?
                                           DMA_SEQ_BYTES_PER_BEAT : DATA_W / 8;
    localparam logic [ADDR_W-1:0] STRIDE      = ADDR_W'(STRIDE_BYTES);
    localparam int unsigned       BURST_MAX_U = BURST_MAX;

    dma_seq_state_e    r_state, w_state_next;
    logic [ADDR_W-1:0] r_src_ptr, r_dst_ptr, w_src_next, w_dst_next;
    logic [LEN_W-1:0]  r_remaining, r_burst, r_beat_cnt;
    logic [LEN_W-1:0]  w_remaining_next, w_burst_next, w_beat_cnt_next;
    logic [LEN_W-1:0]  w_remaining_left;
    logic              r_err;
    logic              r_bus_req, r_bus_write;
    logic [ADDR_W-1:0] r_bus_addr;
    logic              w_bus_req_next, w_bus_write_next;
    logic [ADDR_W-1:0] w_bus_addr_next;
    logic              w_in_burst, w_beat_ok, w_beat_err, w_last_beat, w_abort;
    logic              w_accept;

    assign w_in_burst       = (r_state == S_RD_BURST) || (r_state == S_WR_BURST);
    assign w_beat_ok        = w_in_burst & bus_ready & ~bus_err;
    assign w_beat_err       = w_in_burst & bus_ready & bus_err;
    assign w_last_beat      = (r_beat_cnt == r_burst - LEN_W'(1));
    assign w_remaining_left = r_remaining - r_burst;
    assign w_accept         = (r_state == S_IDLE) && start;

`ifdef DMA_SEQ_ABORT_EN
    // DONE/ERR are already on their way back to IDLE, so abort only bites earlier.
    assign w_abort = abort && (w_in_burst || (r_state == S_NEXT));
`else
    assign w_abort = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (xfer_len != '0) ? S_RD_BURST : S_DONE;
                end
            end
            S_RD_BURST: begin
                if (w_beat_err) begin
                    w_state_next = S_ERR;
                end else if (w_beat_ok && w_last_beat) begin
                    w_state_next = S_WR_BURST;
                end
            end
            S_WR_BURST: begin
                if (w_beat_err) begin
                    w_state_next = S_ERR;
                end else if (w_beat_ok && w_last_beat) begin
                    w_state_next = (w_remaining_left == '0) ? S_DONE : S_NEXT;
                end
            end
            S_NEXT:  w_state_next = S_RD_BURST;
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = S_ERR;
        end
    end

    // Pointer and counter updates; an abort freezes them since the transfer is dead.
    always_comb begin
        w_src_next       = r_src_ptr;
        w_dst_next       = r_dst_ptr;
        w_remaining_next = r_remaining;
        w_burst_next     = r_burst;
        w_beat_cnt_next  = r_beat_cnt;
        if (!w_abort) begin
            case (r_state)
                S_IDLE: begin
                    if (start && (xfer_len != '0)) begin
                        w_src_next       = src_addr;
                        w_dst_next       = dst_addr;
                        w_remaining_next = xfer_len;
                        w_burst_next     = LEN_W'(min_burst(32'(xfer_len), BURST_MAX_U));
                        w_beat_cnt_next  = '0;
                    end
                end
                S_RD_BURST: begin
                    if (w_beat_ok) begin
                        w_src_next      = r_src_ptr + STRIDE;
                        w_beat_cnt_next = w_last_beat ? '0 : r_beat_cnt + LEN_W'(1);
                    end
                end
                S_WR_BURST: begin
                    if (w_beat_ok) begin
                        w_dst_next      = r_dst_ptr + STRIDE;
                        w_beat_cnt_next = w_last_beat ? '0 : r_beat_cnt + LEN_W'(1);
                        if (w_last_beat) begin
                            w_remaining_next = w_remaining_left;
                        end
                    end
                end
                S_NEXT: begin
                    w_burst_next = LEN_W'(min_burst(32'(r_remaining), BURST_MAX_U));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
            r_burst     <= '0;
            r_beat_cnt  <= '0;
        end else begin
            r_src_ptr   <= w_src_next;
            r_dst_ptr   <= w_dst_next;
            r_remaining <= w_remaining_next;
            r_burst     <= w_burst_next;
            r_beat_cnt  <= w_beat_cnt_next;
        end
    end

    // Output logic; bus signals are precomputed from the next state so they register in.
    always_comb begin
        busy             = (r_state != S_IDLE);
        done             = (r_state == S_DONE);
        fifo_clr         = (r_state == S_NEXT) || (r_state == S_DONE) || (r_state == S_ERR);
        fifo_wr_en       = (r_state == S_RD_BURST) & bus_ready & ~bus_err;
        fifo_rd_en       = (r_state == S_WR_BURST) & bus_ready & ~bus_err;
        w_bus_req_next   = (w_state_next == S_RD_BURST) || (w_state_next == S_WR_BURST);
        w_bus_write_next = (w_state_next == S_WR_BURST);
        w_bus_addr_next  = '0;
        if (w_state_next == S_RD_BURST) begin
            w_bus_addr_next = w_src_next;
        end else if (w_state_next == S_WR_BURST) begin
            w_bus_addr_next = w_dst_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_req   <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_addr  <= '0;
        end else begin
            r_bus_req   <= w_bus_req_next;
            r_bus_write <= w_bus_write_next;
            r_bus_addr  <= w_bus_addr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_beat_err && !w_abort) begin
            r_err <= 1'b1;
        end
    end

`ifdef DMA_SEQ_ABORT_EN
    logic r_aborted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aborted <= 1'b0;
        end else if (w_accept) begin
            r_aborted <= 1'b0;
        end else if (w_abort) begin
            r_aborted <= 1'b1;
        end
    end

    assign aborted = r_aborted;
`endif

    assign err       = r_err;
    assign bus_req   = r_bus_req;
    assign bus_write = r_bus_write;
    assign bus_addr  = r_bus_addr;

endmodule

// File: tb/tb_dma_burst_sequencer.sv
// Bench for dma_burst_sequencer: acts as bus slave and fall-through FIFO, and
// checks every completed beat against a burst plan built from the transfer rules.
`timescale 1ns/1ps
module tb_dma_burst_sequencer;

    localparam int BURST_MAX = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] xfer_len = '0;
    logic        busy, done, err, bus_req, bus_write;
    logic [31:0] bus_addr;
    logic        bus_ready = 1'b1;
    logic        bus_err;
    logic        fifo_wr_en, fifo_rd_en, fifo_clr;
`ifdef DMA_SEQ_ABORT_EN
    logic        abort = 1'b0;
    logic        aborted;
`endif

    dma_burst_sequencer #(
        .ADDR_W(32), .DATA_W(32), .LEN_W(16), .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .xfer_len(xfer_len),
        .busy(busy), .done(done), .err(err),
        .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_ready(bus_ready), .bus_err(bus_err),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
`ifdef DMA_SEQ_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .fifo_clr(fifo_clr)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int beat_idx = 0;
    int err_beat = -1;
    int done_count = 0, clr_count = 0, done_cyc = -1, req_cycles = 0, wr_count = 0;
    bit stall_en = 1'b0;

    logic [32:0] exp_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] dst_mem [logic [31:0]];

    assign bus_err = bus_req && (beat_idx == err_beat);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bus_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [31:0] src_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int exp_done(input int len);
        return (len == 0) ? 1 : 2 * len + (len + BURST_MAX - 1) / BURST_MAX;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every transfer is bursts of min(remaining, BURST_MAX): all reads, then all writes.
    task automatic plan(input logic [31:0] s, input logic [31:0] d, input int len);
        int rem;
        int off;
        int n;
        rem = len;
        off = 0;
        exp_q.delete();
        fifo_q.delete();
        dst_mem.delete();
        while (rem > 0) begin
            n = (rem < BURST_MAX) ? rem : BURST_MAX;
            for (int i = 0; i < n; i++) exp_q.push_back({1'b0, s + 32'(4 * (off + i))});
            for (int i = 0; i < n; i++) exp_q.push_back({1'b1, d + 32'(4 * (off + i))});
            off += n;
            rem -= n;
        end
    endtask

    always @(negedge clk) begin : compare
        logic [32:0] e;
        logic good_rd, good_wr;
        if (rst_n) begin
            good_rd = bus_req && !bus_write && bus_ready && !bus_err;
            good_wr = bus_req && bus_write && bus_ready && !bus_err;
            check("fifo_wr_en", 64'(fifo_wr_en), 64'(good_rd));
            check("fifo_rd_en", 64'(fifo_rd_en), 64'(good_wr));
            if (!busy) check("idle_bus_req", 64'(bus_req), 64'(0));
            if (bus_req) req_cycles++;
            if (fifo_wr_en) wr_count++;
            if (bus_req && bus_ready) begin
                check("beat_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("beat_write", 64'(bus_write), 64'(e[32]));
                    check("beat_addr", 64'(bus_addr), 64'(e[31:0]));
                end
                if (good_rd) fifo_q.push_back(src_word(bus_addr));
                if (good_wr) begin
                    check("fifo_nonempty", 64'(fifo_q.size() > 0), 64'(1));
                    if (fifo_q.size() > 0) dst_mem[bus_addr] = fifo_q.pop_front();
                end
                beat_idx++;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc - start_cyc;
            end
            if (fifo_clr) begin
                clr_count++;
                fifo_q.delete();
            end
        end
    end

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input int len);
        plan(s, d, len);
        beat_idx = 0;
        done_count = 0;
        clr_count = 0;
        done_cyc = -1;
        req_cycles = 0;
        wr_count = 0;
        @(posedge clk);
        #1;
        src_addr = s;
        dst_addr = d;
        xfer_len = 16'(len);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int max_cycles);
        bit seen;
        int i;
        seen = 1'b0;
        for (i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            else if (seen) break;
        end
        check("completes", 64'(i < max_cycles), 64'(1));
    endtask

    task automatic check_dst(input logic [31:0] s, input logic [31:0] d, input int len);
        logic [31:0] a;
        for (int i = 0; i < len; i++) begin
            a = d + 32'(4 * i);
            check("dst_present", 64'(dst_mem.exists(a)), 64'(1));
            if (dst_mem.exists(a)) check("dst_data", 64'(dst_mem[a]), 64'(src_word(s + 32'(4 * i))));
        end
        check("dst_count", 64'(dst_mem.num()), 64'(len));
        check("beats_left", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_err"}, 64'(err), 64'(0));
        check({tag, "_bus_req"}, 64'(bus_req), 64'(0));
        check({tag, "_bus_write"}, 64'(bus_write), 64'(0));
        check({tag, "_bus_addr"}, 64'(bus_addr), 64'(0));
        check({tag, "_fifo_wr_en"}, 64'(fifo_wr_en), 64'(0));
        check({tag, "_fifo_rd_en"}, 64'(fifo_rd_en), 64'(0));
        check({tag, "_fifo_clr"}, 64'(fifo_clr), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // L=3: reads cycles 1-3, writes 4-6, done in cycle 7
        check("model_done_L3", 64'(exp_done(3)), 64'(7));
        kick(32'h100, 32'h200, 3);
        wait_end(200);
        $display("xfer L=3 done_cyc=%0d", done_cyc);
        check("L3_done_cycle", 64'(done_cyc), 64'(7));
        check("L3_done_count", 64'(done_count), 64'(1));
        check("L3_clr_count", 64'(clr_count), 64'(1));
        check("L3_err", 64'(err), 64'(0));
        check_dst(32'h100, 32'h200, 3);

        // L=10: bursts of 8 then 2, one NEXT, done in cycle 22
        kick(32'h1000, 32'h2000, 10);
        wait_end(200);
        $display("xfer L=10 done_cyc=%0d", done_cyc);
        check("L10_done_cycle", 64'(done_cyc), 64'(22));
        check("L10_clr_count", 64'(clr_count), 64'(2));
        check_dst(32'h1000, 32'h2000, 10);

        // L=0: done in cycle 1, no bus activity
        kick(32'h300, 32'h400, 0);
        wait_end(50);
        $display("xfer L=0 done_cyc=%0d", done_cyc);
        check("L0_done_cycle", 64'(done_cyc), 64'(1));
        check("L0_req_cycles", 64'(req_cycles), 64'(0));
        check("L0_done_count", 64'(done_count), 64'(1));

        // bus error on the second read beat of L=4
        err_beat = 1;
        kick(32'h500, 32'h600, 4);
        wait_end(100);
        err_beat = -1;
        $display("xfer L=4 bus_err err=%0d done_count=%0d", err, done_count);
        check("berr_err", 64'(err), 64'(1));
        check("berr_done_count", 64'(done_count), 64'(0));
        check("berr_wr_count", 64'(wr_count), 64'(1));
        check("berr_clr_count", 64'(clr_count), 64'(1));
        kick(32'h40, 32'h80, 1);
        check("berr_cleared", 64'(err), 64'(0));
        wait_end(100);
        $display("xfer L=1 after error done_cyc=%0d", done_cyc);
        check("L1_done_cycle", 64'(done_cyc), 64'(exp_done(1)));
        check_dst(32'h40, 32'h80, 1);

        // L=17 with random stalls, source wrapping past the top; extra start ignored
        stall_en = 1'b1;
        fork
            kick(32'hFFFF_FFF0, 32'h5000, 17);
            begin
                repeat (20) @(posedge clk);
                #1;
                src_addr = 32'hAAAA_0000;
                xfer_len = 16'd5;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        wait_end(2000);
        stall_en = 1'b0;
        $display("xfer L=17 stalled done_count=%0d", done_count);
        check("stall_done_count", 64'(done_count), 64'(1));
        check("stall_clr_count", 64'(clr_count), 64'(3));
        check_dst(32'hFFFF_FFF0, 32'h5000, 17);
        repeat (3) @(negedge clk);
        check("stall_stays_idle", 64'(busy), 64'(0));

        // async reset in the middle of the write burst
        kick(32'h700, 32'h900, 8);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_write) break;
        end
        check("reached_write", 64'(bus_write), 64'(1));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        kick(32'h10, 32'h20, 2);
        wait_end(100);
        $display("xfer L=2 after reset done_cyc=%0d", done_cyc);
        check("L2_done_cycle", 64'(done_cyc), 64'(5));
        check_dst(32'h10, 32'h20, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
